// File: rtl/spi_mem_arbiter.sv
// Round-robin fetch/data arbiter serialising each access as one SPI RAM frame (cmd, 24-bit address, 16 data bits).
// Define SPI_MEM_WRITE_EN to enable data-port write frames; otherwise the block is read-only.
module spi_mem_arbiter #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        busy,
  output logic        spi_select,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_e;

`ifdef SPI_MEM_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
  logic unused_wdata;
  assign unused_wdata = ^d_wdata;
`endif

  state_e      state_q;
  logic [6:0]  cnt_q;
  logic [47:0] sh_q;
  logic [15:0] rx_q;
  logic        gnt_q, we_q, last_q;
  logic        f_ack_q, d_ack_q, sel_q, sck_q, mosi_q;
  logic [15:0] f_rdata_q, d_rdata_q;

  // Grant decision and frame image; only consumed in IDLE. gnt/last: 1 = data port.
  logic        gnt_d, we_d, skip_d;
  logic [7:0]  cmd_d;
  logic [15:0] addr_d, wdat_d;
  logic [47:0] frame_d;

  always_comb begin
    gnt_d  = (f_req && d_req) ? ~last_q : d_req;
    we_d   = gnt_d & d_we;
    skip_d = we_d & ~WR_EN;
    addr_d = gnt_d ? d_addr : f_addr;
    cmd_d  = we_d ? CMD_WRITE : CMD_READ;
`ifdef SPI_MEM_WRITE_EN
    wdat_d = we_d ? d_wdata : 16'h0000;
`else
    wdat_d = 16'h0000;
`endif
    frame_d = {cmd_d, 7'b0, addr_d, 1'b0, wdat_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rx_q      <= '0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      last_q    <= 1'b1;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      sel_q     <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sel_q  <= 1'b0;
          sck_q  <= 1'b0;
          mosi_q <= 1'b0;
          if (f_req || d_req) begin
            state_q <= START;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            last_q  <= gnt_d;
            sh_q    <= frame_d;
            sel_q   <= ~skip_d;
            mosi_q  <= skip_d ? 1'b0 : frame_d[47];
          end
        end
        START: begin
          cnt_q <= '0;
          // A write with the write path compiled out completes without touching the bus.
          if (we_q && !WR_EN) begin
            state_q <= DONE;
            d_ack_q <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 7'd1;
          if (!cnt_q[0]) begin
            sck_q <= 1'b1;
          end else begin
            sck_q  <= 1'b0;
            rx_q   <= {rx_q[14:0], spi_miso};
            sh_q   <= {sh_q[46:0], 1'b0};
            mosi_q <= sh_q[46];
            if (cnt_q == 7'd95) begin
              state_q <= DONE;
              sel_q   <= 1'b0;
              mosi_q  <= 1'b0;
              if (gnt_q) d_ack_q <= 1'b1;
              else       f_ack_q <= 1'b1;
              if (!we_q) begin
                if (gnt_q) d_rdata_q <= {rx_q[14:0], spi_miso};
                else       f_rdata_q <= {rx_q[14:0], spi_miso};
              end
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f_ack       = f_ack_q;
  assign d_ack       = d_ack_q;
  assign f_rdata     = f_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = (state_q != IDLE);
  assign spi_select  = sel_q;
  assign spi_clk     = sck_q;
  assign spi_mosi    = mosi_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: behavioural SPI RAM model plus per-scenario tasks with an expected-result queue.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_ack, d_ack, busy, spi_select, spi_clk, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [15:0] f_rdata, d_rdata;
  logic [1:0]  dbg_state;

`ifdef SPI_MEM_WRITE_EN
  localparam logic [15:0] D_WORD = 16'h1234;
`else
  localparam logic [15:0] D_WORD = 16'h5A5A;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  spi_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
    .spi_select(spi_select), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .dbg_state_o(dbg_state)
  );

  // SPI RAM model, word-indexed by byte address bits [8:1]
  logic [15:0] ram [0:255];
  logic        ram_loaded = 1'b0;
  int          bit_cnt = 0;
  int          sel_rises = 0;
  int          last_bits = 0;
  logic [47:0] rx_frame = '0;
  logic [47:0] last_frame = '0;
  logic [15:0] tx_word = '0;
  logic        rd_frame = 1'b0;
  logic        prev_sel = 1'b0;
  logic        prev_sck = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
      ram[8'h10] = 16'hBEEF;
      ram[8'h04] = 16'h5A5A;
      ram[8'h20] = 16'h1111;
      ram[8'h18] = 16'hCAFE;
      ram_loaded = 1'b1;
    end
    if (spi_select && !prev_sel) begin
      bit_cnt = 0;
      sel_rises++;
    end
    if (spi_select && spi_clk && !prev_sck) begin
      rx_frame = {rx_frame[46:0], spi_mosi};
      bit_cnt++;
      if (bit_cnt == 32) begin
        rd_frame = (rx_frame[31:24] == 8'h03);
        tx_word  = ram[rx_frame[8:1]];
      end
      if (bit_cnt >= 32 && bit_cnt < 48 && rd_frame) spi_miso <= tx_word[47-bit_cnt];
      else spi_miso <= 1'b0;
    end
    if (!spi_select && prev_sel) begin
      last_frame = rx_frame;
      last_bits  = bit_cnt;
      if (bit_cnt == 48 && rx_frame[47:40] == 8'h02) ram[rx_frame[24:17]] = rx_frame[15:0];
    end
    prev_sel = spi_select;
    prev_sck = spi_clk;
  end

  task automatic apply_reset();
    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_any(output bit was_d, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!(f_ack || d_ack) && lat < 400);
    was_d = d_ack;
  endtask

  // Drives one request at a negedge, drops it in the ack cycle, returns one cycle after the ack.
  task automatic do_xfer(input bit is_d, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                         output bit was_d, output int lat, output logic [15:0] rdata, output logic busy_at_ack);
    @(negedge clk);
    if (is_d) begin d_addr = addr; d_we = we; d_wdata = wdata; d_req = 1'b1; end
    else begin f_addr = addr; f_req = 1'b1; end
    wait_any(was_d, lat);
    rdata = was_d ? d_rdata : f_rdata;
    busy_at_ack = busy;
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({f_ack, d_ack, busy, spi_select, spi_clk, spi_mosi} !== 6'b0) $display("FAIL reset_outs: got %b expected 000000", {f_ack, d_ack, busy, spi_select, spi_clk, spi_mosi});
    else n_pass++;
    n_checks++;
    if ({f_rdata, d_rdata} !== 32'h0) $display("FAIL reset_rdata: got %h expected 00000000", {f_rdata, d_rdata});
    else n_pass++;
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state);
    else n_pass++;
  endtask

  task automatic test_fetch_read();
    bit was_d; int lat; logic [15:0] rd; logic bz; logic [16:0] exp;
    int rises0;
    rises0 = sel_rises;
    exp_q.push_back({1'b0, 16'hBEEF});
    do_xfer(1'b0, 1'b0, 16'h0010, 16'h0, was_d, lat, rd, bz);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 98) $display("FAIL fetch_latency: got %0d expected 98", lat); else n_pass++;
    n_checks++;
    if ({was_d, rd} !== exp) $display("FAIL fetch_data: got %h expected %h", {was_d, rd}, exp); else n_pass++;
    n_checks++;
    if (bz !== 1'b1) $display("FAIL fetch_busy_at_ack: got %b expected 1", bz); else n_pass++;
    n_checks++;
    if (last_frame[47:16] !== 32'h03000020) $display("FAIL fetch_frame: got %h expected 03000020", last_frame[47:16]); else n_pass++;
    n_checks++;
    if (last_bits !== 48 || sel_rises !== rises0 + 1) $display("FAIL fetch_sck_edges: got %0d/%0d expected 48/%0d", last_bits, sel_rises, rises0 + 1);
    else n_pass++;
    n_checks++;
    if ({f_ack, busy, spi_select} !== 3'b000) $display("FAIL fetch_ack_pulse: got %b expected 000", {f_ack, busy, spi_select}); else n_pass++;
  endtask

  task automatic test_data_read(input logic [15:0] expect_word);
    bit was_d; int lat; logic [15:0] rd; logic bz; logic [16:0] exp;
    exp_q.push_back({1'b1, expect_word});
    do_xfer(1'b1, 1'b0, 16'h0004, 16'hFFFF, was_d, lat, rd, bz);
    exp = exp_q.pop_front();
    n_checks++;
    if ({was_d, rd} !== exp) $display("FAIL data_read: got %h expected %h", {was_d, rd}, exp); else n_pass++;
    n_checks++;
    if (last_frame[47:16] !== 32'h03000008 || lat !== 98) $display("FAIL data_read_frame: got %h lat %0d expected 03000008 lat 98", last_frame[47:16], lat);
    else n_pass++;
    n_checks++;
    if (f_rdata !== 16'hBEEF) $display("FAIL f_rdata_hold: got %h expected beef", f_rdata); else n_pass++;
  endtask

  task automatic test_write();
    bit was_d; int lat; logic [15:0] rd; logic bz; logic [16:0] exp;
    int rises0;
    rises0 = sel_rises;
    exp_q.push_back({1'b1, 16'h5A5A});
    do_xfer(1'b1, 1'b1, 16'h0004, 16'h1234, was_d, lat, rd, bz);
    exp = exp_q.pop_front();
    n_checks++;
    if ({was_d, rd} !== exp) $display("FAIL write_rdata_unchanged: got %h expected %h", {was_d, rd}, exp); else n_pass++;
`ifdef SPI_MEM_WRITE_EN
    n_checks++;
    if (lat !== 98) $display("FAIL write_latency: got %0d expected 98", lat); else n_pass++;
    n_checks++;
    if (last_frame !== 48'h020000081234) $display("FAIL write_frame: got %h expected 020000081234", last_frame); else n_pass++;
    n_checks++;
    if (ram[8'h04] !== 16'h1234) $display("FAIL write_ram: got %h expected 1234", ram[8'h04]); else n_pass++;
`else
    n_checks++;
    if (lat !== 2) $display("FAIL ro_write_latency: got %0d expected 2", lat); else n_pass++;
    n_checks++;
    if (sel_rises !== rises0) $display("FAIL ro_write_select: got %0d rises expected %0d", sel_rises, rises0); else n_pass++;
    n_checks++;
    if (ram[8'h04] !== 16'h5A5A) $display("FAIL ro_write_ram: got %h expected 5a5a", ram[8'h04]); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    bit was_d; int lat; logic [16:0] exp;
    apply_reset();
    @(negedge clk);
    f_addr = 16'h0010; d_addr = 16'h0004; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    exp_q.push_back({1'b0, 16'hBEEF});
    exp_q.push_back({1'b1, D_WORD});
    exp_q.push_back({1'b0, 16'hBEEF});
    for (int i = 0; i < 3; i++) begin
      wait_any(was_d, lat);
      exp = exp_q.pop_front();
      n_checks++;
      if ({was_d, was_d ? d_rdata : f_rdata} !== exp) $display("FAIL rr_grant%0d: got %h expected %h", i, {was_d, was_d ? d_rdata : f_rdata}, exp);
      else n_pass++;
      n_checks++;
      if (lat !== ((i == 0) ? 98 : 99)) $display("FAIL rr_period%0d: got %0d expected %0d", i, lat, (i == 0) ? 98 : 99);
      else n_pass++;
    end
    f_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rr_idle_after: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    bit was_d; int lat; logic [15:0] rd; logic bz; int acks;
    @(negedge clk);
    f_addr = 16'h0018; f_req = 1'b1;
    repeat (42) @(posedge clk);
    #2;
    n_checks++;
    if ({dbg_state, spi_select} !== 3'b101) $display("FAIL mid_shift_state: got %b expected 101", {dbg_state, spi_select}); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spi_select, spi_clk, busy} !== 3'b000) $display("FAIL async_reset: got %b expected 000", {spi_select, spi_clk, busy}); else n_pass++;
    f_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (120) begin
      @(negedge clk);
      if (f_ack || d_ack) acks++;
    end
    n_checks++;
    if (acks !== 0) $display("FAIL abandoned_ack: got %0d acks expected 0", acks); else n_pass++;
    exp_q.push_back({1'b0, 16'hCAFE});
    do_xfer(1'b0, 1'b0, 16'h0018, 16'h0, was_d, lat, rd, bz);
    n_checks++;
    if ({was_d, rd} !== exp_q[0] || lat !== 98) $display("FAIL refetch: got %h lat %0d expected %h lat 98", {was_d, rd}, lat, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_input_change();
    bit was_d; int lat; logic [16:0] exp;
    @(negedge clk);
    f_addr = 16'h0010; f_req = 1'b1;
    exp_q.push_back({1'b0, 16'hBEEF});
    repeat (5) @(posedge clk);
    @(negedge clk) f_addr = 16'h0020;
    wait_any(was_d, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if ({was_d, f_rdata} !== exp) $display("FAIL latched_addr_data: got %h expected %h", {was_d, f_rdata}, exp); else n_pass++;
    f_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (last_frame[47:16] !== 32'h03000020) $display("FAIL latched_addr_frame: got %h expected 03000020", last_frame[47:16]); else n_pass++;
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_fetch_read();
    test_data_read(16'h5A5A);
    test_write();
    test_data_read(D_WORD);
    test_back_to_back();
    test_reset_mid_shift();
    test_input_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
